// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle register-file sequencer: read, ALU execute, shift-add multiply, write-back
module exec_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [3:0]       in_rd,
   input  logic [3:0]       in_rs,
   input  logic [7:0]       in_imm,
   output logic [3:0]       rd_sel_1,
   output logic [3:0]       rd_sel_2,
   input  logic [WIDTH-1:0] rd_data_1,
   input  logic [WIDTH-1:0] rd_data_2,
   output logic [3:0]       wr_sel_1,
   output logic             wr_en_1,
   output logic [WIDTH-1:0] wr_data_1,
   output logic [3:0]       wr_sel_2,
   output logic             wr_en_2,
   output logic [WIDTH-1:0] wr_data_2,
   output logic [4:0]       flags,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MUL   = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_CMP  = 4'd6;
   localparam logic [3:0] OP_LSH  = 4'd7;
   localparam logic [3:0] OP_RSH  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_ADDI = 4'd10;

   // Flag bit positions within {C,L,F,Z,N}
   localparam int F_C = 4;
   localparam int F_L = 3;
   localparam int F_F = 2;
   localparam int F_Z = 1;
   localparam int F_N = 0;

   logic [2:0]       state;
   logic [3:0]       op;
   logic [7:0]       imm;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] wr_value;
   logic [3:0]       cnt;
   logic [4:0]       flags_next;
   logic             illegal;
   logic             load_write;
   logic             to_port2;

   assign in_ready = (state == S_IDLE);
   assign illegal  = (op > OP_ADDI);
   // rd_sel_1 keeps the latched destination for the whole operation
   assign to_port2 = (rd_sel_1 == 4'd12) || (rd_sel_1 == 4'd13);
   assign b_eff    = (op == OP_ADDI) ? {{(WIDTH-8){imm[7]}}, imm} : b;
   assign sum      = {1'b0, a} + {1'b0, b_eff};
   assign diff     = {1'b0, a} - {1'b0, b};
   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign load_write = ((state == S_EXEC) && !illegal && (op != OP_CMP) && (op != OP_MUL)) ||
                       ((state == S_MUL) && (cnt == 4'd15));
   assign wr_value = (state == S_MUL) ? acc_next : alu_res;

   always_comb begin
      alu_res    = '0;
      flags_next = flags;
      case (op)
         OP_ADD, OP_ADDI: begin
            alu_res         = sum[WIDTH-1:0];
            flags_next[F_C] = sum[WIDTH];
            flags_next[F_F] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res         = diff[WIDTH-1:0];
            flags_next[F_C] = diff[WIDTH];
            flags_next[F_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_MOV: alu_res = b;
         OP_CMP: begin
            flags_next[F_C] = diff[WIDTH];
            flags_next[F_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            flags_next[F_L] = (a < b);
            flags_next[F_Z] = (a == b);
            flags_next[F_N] = ($signed(a) < $signed(b));
         end
         OP_LSH: alu_res = a << b[3:0];
         OP_RSH: alu_res = a >> b[3:0];
         default: alu_res = '0;
      endcase
      if (op != OP_CMP) begin
         flags_next[F_Z] = (alu_res == '0);
         flags_next[F_N] = alu_res[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op        <= '0;
         imm       <= '0;
         a         <= '0;
         b         <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         flags     <= '0;
         rd_sel_1  <= '0;
         rd_sel_2  <= '0;
         wr_sel_1  <= '0;
         wr_sel_2  <= '0;
         wr_data_1 <= '0;
         wr_data_2 <= '0;
         wr_en_1   <= 1'b0;
         wr_en_2   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         wr_en_1 <= 1'b0;
         wr_en_2 <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op       <= in_op;
                  imm      <= in_imm;
                  rd_sel_1 <= in_rd;
                  rd_sel_2 <= in_rs;
                  state    <= S_READ;
               end
            end
            S_READ: begin
               a     <= rd_data_1;
               b     <= rd_data_2;
               // CMP and illegal ops complete in EXEC, so their pulse is launched here
               done  <= (op == OP_CMP) || illegal;
               err   <= illegal;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (illegal) begin
                  state <= S_IDLE;
               end else if (op == OP_CMP) begin
                  flags <= flags_next;
                  state <= S_IDLE;
               end else if (op == OP_MUL) begin
                  acc    <= '0;
                  mcand  <= a;
                  mplier <= b;
                  cnt    <= '0;
                  state  <= S_MUL;
               end else begin
                  flags <= flags_next;
                  state <= S_WRITE;
               end
            end
            S_MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  flags[F_Z] <= (acc_next == '0);
                  flags[F_N] <= acc_next[WIDTH-1];
                  state      <= S_WRITE;
               end
            end
            S_WRITE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (load_write) begin
            done <= 1'b1;
            if (to_port2) begin
               wr_en_2   <= 1'b1;
               wr_sel_2  <= rd_sel_1;
               wr_data_2 <= wr_value;
            end else begin
               wr_en_1   <= 1'b1;
               wr_sel_1  <= rd_sel_1;
               wr_data_1 <= wr_value;
            end
         end
      end
   end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; only 16 is supported.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  instruction offered.
REQ-005 SHALL have port in_ready  out  1  sequencer can accept.
REQ-006 SHALL have port in_op  in  4  opcode.
REQ-007 SHALL have port in_rd  in  4  destination and operand A register.
REQ-008 SHALL have port in_rs  in  4  operand B register.
REQ-009 SHALL have port in_imm  in  8  immediate for ADDI.
REQ-010 SHALL have ports rd_sel_1 and rd_sel_2  out  4 each  register-file read selects.
REQ-011 SHALL have ports rd_data_1 and rd_data_2  in  16 each  register-file read data, combinational from the selects.
REQ-012 SHALL have ports wr_sel_1 out 4, wr_en_1 out 1, wr_data_1 out 16  write port 1 (registers 0-11, 14, 15).
REQ-013 SHALL have ports wr_sel_2 out 4, wr_en_2 out 1, wr_data_2 out 16  write port 2 (registers 12, 13 only).
REQ-014 SHALL have port flags  out  5  {C,L,F,Z,N}.
REQ-015 SHALL have ports done out 1 and err out 1  single-cycle completion and illegal-op pulses.

Function
REQ-016 SHALL implement states IDLE, READ, EXEC, MUL, WRITE; in_ready=1 only in IDLE.
REQ-017 SHALL transition IDLE->READ on in_valid&in_ready, latching op, rd, rs, imm.
REQ-018 SHALL, in READ, drive rd_sel_1=rd and rd_sel_2=rs, capture A=rd_data_1 and B=rd_data_2 at the end of the cycle, then go to EXEC; selects hold their last value otherwise.
REQ-019 SHALL decode opcodes as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV (B), 6 CMP, 7 LSH (A<<B[3:0]), 8 RSH (logical, A>>B[3:0]), 9 MUL (low 16 bits of A*B), 10 ADDI (A+sign-extended imm); 11-15 are illegal.
REQ-020 SHALL, in EXEC, register the result and flags, then go to WRITE, except that MUL goes to MUL and ops 6 and 11-15 go to IDLE.
REQ-021 SHALL, in MUL, run a shift-add loop for exactly 16 cycles, then go to WRITE.
REQ-022 SHALL assert the write strobe for exactly one cycle in WRITE: rd in 12/13 -> wr_en_2/wr_sel_2/wr_data_2, else wr_en_1/wr_sel_1/wr_data_1; never both; then go to IDLE.
REQ-023 SHALL pulse done for one cycle in the WRITE cycle, and in the EXEC cycle for CMP and illegal ops.
REQ-024 SHALL pulse err alongside done for opcodes 11-15, with no write and flags unchanged.
REQ-025 SHALL give latency from accept edge to write-strobe cycle of 3 cycles for non-MUL ops and 19 cycles for MUL; back-to-back issue throughput is 1 op per 4 (or 20) cycles.
REQ-026 SHALL set flags as follows:
- C: ADD/ADDI carry-out; SUB/CMP borrow.
- F: signed overflow for ADD/ADDI/SUB/CMP.
- L: A<B unsigned, CMP only.
- Z: result==0 (CMP: A==B).
- N: result[15] (CMP: A<B signed).
- Flags not listed for an op hold their previous value.
REQ-027 SHALL treat rd==rs as legal (A==B); all arithmetic is modulo 2^16; a shift count of 0 passes A.
REQ-028 SHALL ignore in_valid outside IDLE; the instruction is not consumed.

Reset
REQ-029 SHALL, on reset, go to IDLE and clear flags, wr_en_1, wr_en_2, done, err, rd_sel_1/2, wr_sel_1/2, and wr_data_1/2 to 0; in_ready=1 in the cycle after reset.
REQ-030 SHALL abort any operation in flight on reset, including MUL mid-loop, with no write strobe issued.

Verification
REQ-031 SHALL check: R1=0x7FFF, R2=0x0001, ADD rd=1 rs=2 -> wr_en_1 with sel 1, data 0x8000 three cycles after accept; F=1, N=1, C=0, Z=0.
REQ-032 SHALL check: R3=5, R4=5, CMP -> done in the EXEC cycle, no write, Z=1, L=0, C=0.
REQ-033 SHALL check: R12=0x0003, R5=0x0007, MUL rd=12 -> wr_en_2 sel 12 data 0x0015 19 cycles after accept; wr_en_1 stays 0.
REQ-034 SHALL check: op 13 -> done and err for one cycle, flags unchanged, no write strobe, in_ready back next cycle.
REQ-035 SHALL check: reset asserted during MUL cycle 8 -> no write, all outputs 0 next cycle, in_ready=1.
REQ-036 SHALL check: in_valid held high for consecutive ADDI ops (imm=0xFF on R0=0) -> each accepted only in IDLE, R0 results 0xFFFF then 0xFFFE, C=0 then C=1.
